// File: rtl/maxnet_host_if.sv
// maxnet_host_if: sample stream, engine and result stream signals of the MaxNet host.
interface maxnet_host_if #(
  parameter int WIDTH = 5,
  parameter int LANES = 4
);
  localparam int IW = $clog2(LANES);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [LANES*WIDTH-1:0] net_x;
  logic                   net_start;
  logic                   net_done;
  logic [WIDTH-1:0]       net_max;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_max;
  logic [IW-1:0]          out_index;
  logic                   out_err;
  modport master (
    output in_valid, in_data, net_done, net_max, out_ready,
    input  in_ready, net_x, net_start, out_valid, out_max, out_index, out_err
  );
  modport slave (
    input  in_valid, in_data, net_done, net_max, out_ready,
    output in_ready, net_x, net_start, out_valid, out_max, out_index, out_err
  );
endinterface

// File: rtl/maxnet_host.sv
// maxnet_host: collects LANES samples, launches the MaxNet engine, returns max and lowest matching lane.
// Optional WAIT watchdog enabled by defining MAXNET_HOST_TIMEOUT_EN (adds parameter TIMEOUT).
module maxnet_host #(
  parameter int WIDTH = 5,
  parameter int LANES = 4
`ifdef MAXNET_HOST_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic clock,
  input  logic reset,
  maxnet_host_if.slave b,
  output logic busy
);
  localparam int IW = $clog2(LANES);
  typedef enum logic [1:0] {FILL, LAUNCH, WAIT, RESULT} state_t;
  state_t                      state_q, state_d;
  logic [IW-1:0]               cnt_q, cnt_d;
  logic [LANES-1:0][WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0]            max_q, max_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        err_q, err_d;
  logic                        start_q, start_d;
  logic                        valid_q, valid_d;
  logic                        m_hit;
  logic [IW-1:0]               m_idx;
`ifdef MAXNET_HOST_TIMEOUT_EN
  logic [15:0]                 tmo_q, tmo_d;
`endif
  assign b.in_ready  = state_q == FILL;
  assign b.net_x     = x_q;
  assign b.net_start = start_q;
  assign b.out_valid = valid_q;
  assign b.out_max   = max_q;
  assign b.out_index = idx_q;
  assign b.out_err   = err_q;
  assign busy        = state_q != FILL;
  // Scan from the top lane down so the lowest matching lane wins.
  always_comb begin
    m_hit = 1'b0;
    m_idx = '0;
    for (int k = LANES - 1; k >= 0; k--)
      if (x_q[k] == b.net_max) begin
        m_hit = 1'b1;
        m_idx = IW'(k);
      end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    max_d   = max_q;
    idx_d   = idx_q;
    err_d   = err_q;
    start_d = 1'b0;
    valid_d = valid_q;
`ifdef MAXNET_HOST_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      FILL: if (b.in_valid) begin
        x_d[cnt_q] = b.in_data;
        cnt_d      = cnt_q == IW'(LANES - 1) ? '0 : cnt_q + IW'(1);
        state_d    = cnt_q == IW'(LANES - 1) ? LAUNCH : FILL;
        start_d    = cnt_q == IW'(LANES - 1);
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef MAXNET_HOST_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT: begin
        if (b.net_done) begin
          max_d   = b.net_max;
          idx_d   = m_hit ? m_idx : '0;
          err_d   = !m_hit;
          valid_d = 1'b1;
          state_d = RESULT;
        end
`ifdef MAXNET_HOST_TIMEOUT_EN
        else if (tmo_q == 16'(TIMEOUT - 1)) begin
          max_d   = '0;
          idx_d   = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = RESULT;
        end
        tmo_d = tmo_q + 16'd1;
`endif
      end
      default: if (b.out_ready) begin
        valid_d = 1'b0;
        state_d = FILL;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      x_q     <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef MAXNET_HOST_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      start_q <= start_d;
      valid_q <= valid_d;
`ifdef MAXNET_HOST_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_maxnet_host.sv
// tb_maxnet_host: directed checks of the MaxNet host with hand-computed expectations.
module tb_maxnet_host;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;
  maxnet_host_if #(.WIDTH(5), .LANES(4)) bus ();
`ifdef MAXNET_HOST_TIMEOUT_EN
  maxnet_host #(.WIDTH(5), .LANES(4), .TIMEOUT(8)) dut (.clock(clock), .reset(reset), .b(bus.slave), .busy(busy));
`else
  maxnet_host #(.WIDTH(5), .LANES(4)) dut (.clock(clock), .reset(reset), .b(bus.slave), .busy(busy));
`endif
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push(input logic [4:0] v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask
  task automatic fill4(input logic [4:0] a, input logic [4:0] b2, input logic [4:0] c, input logic [4:0] d);
    push(a);
    push(b2);
    push(c);
    push(d);
  endtask
  task automatic done_pulse(input logic [4:0] m);
    bus.net_done = 1'b1;
    bus.net_max  = m;
    @(negedge clock);
    bus.net_done = 1'b0;
  endtask
  task automatic chk_res(input string tag, input logic [4:0] m, input logic [1:0] i, input logic e);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_max"}, 32'(bus.out_max), 32'(m));
    chk({tag, "_idx"}, 32'(bus.out_index), 32'(i));
    chk({tag, "_err"}, 32'(bus.out_err), 32'(e));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.net_done = 1'b0; bus.net_max = '0; bus.out_ready = 1'b1;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_netx", 32'(bus.net_x), 32'd0);
    chk("rst_start", 32'(bus.net_start), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rel_inready", 32'(bus.in_ready), 32'd1);
    // Basic run: 3,17,9,12 -> max 17 at lane 1
    fill4(5'd3, 5'd17, 5'd9, 5'd12);
    chk("t1_start", 32'(bus.net_start), 32'd1);
    chk("t1_inready", 32'(bus.in_ready), 32'd0);
    chk("t1_netx", 32'(bus.net_x), {12'd0, 5'd12, 5'd9, 5'd17, 5'd3});
    @(negedge clock);
    chk("t1_start_off", 32'(bus.net_start), 32'd0);
    repeat (3) @(negedge clock);
    chk("t1_novalid", 32'(bus.out_valid), 32'd0);
    done_pulse(5'd17);
    chk_res("t1", 5'd17, 2'd1, 1'b0);
    chk("t1_hs_inready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    chk("t1_valid_off", 32'(bus.out_valid), 32'd0);
    chk("t1_inready", 32'(bus.in_ready), 32'd1);
    // Duplicates: lowest matching lane wins
    fill4(5'd20, 5'd7, 5'd20, 5'd1);
    @(negedge clock);
    done_pulse(5'd20);
    chk_res("dup", 5'd20, 2'd0, 1'b0);
    @(negedge clock);
    fill4(5'd20, 5'd7, 5'd20, 5'd1);
    @(negedge clock);
    done_pulse(5'd31);
    chk_res("nomatch", 5'd31, 2'd0, 1'b1);
    @(negedge clock);
    // Backpressure on the result stream
    bus.out_ready = 1'b0;
    fill4(5'd5, 5'd6, 5'd7, 5'd8);
    @(negedge clock);
    done_pulse(5'd8);
    bus.in_valid = 1'b1;
    bus.in_data  = 5'd30;
    for (int i = 0; i < 10; i++) begin
      chk_res("bp", 5'd8, 2'd3, 1'b0);
      chk("bp_inready", 32'(bus.in_ready), 32'd0);
      @(negedge clock);
    end
    chk("bp_netx", 32'(bus.net_x), {12'd0, 5'd8, 5'd7, 5'd6, 5'd5});
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_netx", 32'(bus.net_x), {12'd0, 5'd8, 5'd7, 5'd6, 5'd5});
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("bp_lane0", 32'(bus.net_x), {12'd0, 5'd8, 5'd7, 5'd6, 5'd30});
    // Stale done held high through LAUNCH; lanes become {30,1,2,3}
    bus.net_done = 1'b1;
    bus.net_max  = 5'd2;
    push(5'd1);
    push(5'd2);
    push(5'd3);
    chk("stale_launch_start", 32'(bus.net_start), 32'd1);
    chk("stale_launch_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    chk("stale_wait_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    bus.net_done = 1'b0;
    chk_res("stale", 5'd2, 2'd2, 1'b0);
    @(negedge clock);
    // Asynchronous reset in WAIT
    fill4(5'd1, 5'd2, 5'd3, 5'd4);
    repeat (2) @(negedge clock);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_netx", 32'(bus.net_x), 32'd0);
    chk("arst_max", 32'(bus.out_max), 32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_inready", 32'(bus.in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    push(5'd9);
    chk("arst_lane0", 32'(bus.net_x), 32'd9);
    push(5'd10);
    push(5'd11);
    push(5'd12);
    @(negedge clock);
    done_pulse(5'd11);
    chk_res("after_rst", 5'd11, 2'd2, 1'b0);
    @(negedge clock);
`ifdef MAXNET_HOST_TIMEOUT_EN
    fill4(5'd4, 5'd5, 5'd6, 5'd7);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("tmo_wait", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clock);
    chk_res("tmo", 5'd0, 2'd0, 1'b1);
    @(negedge clock);
    fill4(5'd4, 5'd5, 5'd6, 5'd7);
    repeat (7) @(negedge clock);
    done_pulse(5'd6);
    chk_res("tmo_edge", 5'd6, 2'd2, 1'b0);
    @(negedge clock);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
